// File: rtl/rpn_controller.sv
// Command sequencer for the RPN calculator operand stack: decodes one command at a time and drives the stack strobes.
// Optional feature: define RPN_MOD_EN to enable opcode 11 (MOD) on the shared divider.
module rpn_controller #(
   parameter int WIDTH = 32,
   parameter int RADIX = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [3:0]       cmd_digit,
   input  logic [WIDTH-1:0] stack_top,
   input  logic [WIDTH-1:0] stack_next,
   input  logic [5:0]       stack_count,
   input  logic             stack_error,
   output logic             stack_push,
   output logic             stack_pop,
   output logic             stack_write,
   output logic [WIDTH-1:0] stack_value,
   output logic             stack_reset,
   output logic             op_done,
   output logic [1:0]       err_code,
   output logic [1:0]       debug_state
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] RADIX_W = WIDTH'(RADIX);

   localparam logic [3:0] OP_DIGIT   = 4'd1;
   localparam logic [3:0] OP_ENTER   = 4'd2;
   localparam logic [3:0] OP_DROP    = 4'd3;
   localparam logic [3:0] OP_ADD     = 4'd4;
   localparam logic [3:0] OP_SUB     = 4'd5;
   localparam logic [3:0] OP_MUL     = 4'd6;
   localparam logic [3:0] OP_DIV     = 4'd7;
   localparam logic [3:0] OP_NEG     = 4'd8;
   localparam logic [3:0] OP_CLEAR   = 4'd9;
   localparam logic [3:0] OP_CLR_ALL = 4'd10;
`ifdef RPN_MOD_EN
   localparam logic [3:0] OP_MOD     = 4'd11;
`endif

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXEC    = 2'd1,
      S_DIV_RUN = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
   // cmd_ready is high only in IDLE with reset released, and cmd_valid is ignored otherwise.
   logic accept;
   assign cmd_ready   = (state == S_IDLE) && reset;
   assign accept      = cmd_valid && cmd_ready;
   assign debug_state = state;

   logic [WIDTH-1:0] div_q, div_d, div_r;
   logic [CW-1:0]    div_cnt;
   logic             div_neg_q;
`ifdef RPN_MOD_EN
   logic             div_is_mod, div_neg_r;
   logic             is_mod_nxt, neg_r_nxt;
`endif

   logic             push_nxt, pop_nxt, write_nxt, sreset_nxt, done_nxt;
   logic [WIDTH-1:0] value_nxt;
   logic [1:0]       err_nxt;
   logic [WIDTH-1:0] q_nxt, d_nxt, r_nxt;
   logic [CW-1:0]    cnt_nxt;
   logic             neg_q_nxt;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] a);
      return a[WIDTH-1] ? -a : a;
   endfunction

   // One restoring step: shift the next dividend bit into the partial remainder.
   logic [WIDTH:0]   div_shift;
   logic             div_fit;
   logic [WIDTH-1:0] step_q, step_r, quot_signed, rem_signed;
   always_comb begin
      div_shift   = {div_r, div_q[WIDTH-1]};
      div_fit     = (div_shift >= {1'b0, div_d});
      step_r      = div_fit ? WIDTH'(div_shift - {1'b0, div_d}) : div_shift[WIDTH-1:0];
      step_q      = {div_q[WIDTH-2:0], div_fit};
      quot_signed = div_neg_q ? -step_q : step_q;
`ifdef RPN_MOD_EN
      rem_signed  = div_neg_r ? -step_r : step_r;
`else
      rem_signed  = '0;
`endif
   end

   logic       is_div_op, is_binary, digit_ok;
   logic [1:0] accept_err;
   always_comb begin
      is_div_op = (cmd_op == OP_DIV);
`ifdef RPN_MOD_EN
      if (cmd_op == OP_MOD) is_div_op = 1'b1;
`endif
      is_binary = is_div_op || (cmd_op == OP_ADD) || (cmd_op == OP_SUB) || (cmd_op == OP_MUL);
      digit_ok  = (int'(cmd_digit) < RADIX);
      accept_err = 2'd0;
      if (is_binary && stack_count == 6'd1)
         accept_err = 2'd1;
      else if (cmd_op == OP_ENTER && (stack_count == 6'd0 || stack_error))
         accept_err = 2'd2;
      else if (is_div_op && stack_top == '0)
         accept_err = 2'd3;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      push_nxt   = 1'b0;
      pop_nxt    = 1'b0;
      write_nxt  = 1'b0;
      sreset_nxt = 1'b0;
      done_nxt   = 1'b0;
      value_nxt  = '0;
      err_nxt    = err_code;
      q_nxt      = div_q;
      d_nxt      = div_d;
      r_nxt      = div_r;
      cnt_nxt    = div_cnt;
      neg_q_nxt  = div_neg_q;
`ifdef RPN_MOD_EN
      is_mod_nxt = div_is_mod;
      neg_r_nxt  = div_neg_r;
`endif
      case (state)
         S_IDLE: begin
            if (accept) begin
               err_nxt = accept_err;
               if (is_div_op && accept_err == 2'd0) begin
                  state_nxt = S_DIV_RUN;
                  q_nxt     = magnitude(stack_next);
                  d_nxt     = magnitude(stack_top);
                  r_nxt     = '0;
                  cnt_nxt   = '0;
                  neg_q_nxt = stack_next[WIDTH-1] ^ stack_top[WIDTH-1];
`ifdef RPN_MOD_EN
                  is_mod_nxt = (cmd_op == OP_MOD);
                  neg_r_nxt  = stack_next[WIDTH-1];
`endif
               end else begin
                  state_nxt = S_EXEC;
                  done_nxt  = 1'b1;
                  if (accept_err == 2'd0) begin
                     case (cmd_op)
                        OP_DIGIT: if (digit_ok) begin
                           write_nxt = 1'b1;
                           value_nxt = stack_top * RADIX_W + WIDTH'(cmd_digit);
                        end
                        OP_ENTER: push_nxt = 1'b1;
                        OP_DROP: begin
                           // A single remaining element is zeroed rather than removed.
                           if (stack_count == 6'd1) write_nxt = 1'b1;
                           else                     pop_nxt   = 1'b1;
                        end
                        OP_ADD: begin
                           pop_nxt = 1'b1; write_nxt = 1'b1; value_nxt = stack_next + stack_top;
                        end
                        OP_SUB: begin
                           pop_nxt = 1'b1; write_nxt = 1'b1; value_nxt = stack_next - stack_top;
                        end
                        OP_MUL: begin
                           pop_nxt = 1'b1; write_nxt = 1'b1; value_nxt = stack_next * stack_top;
                        end
                        OP_NEG: begin
                           write_nxt = 1'b1; value_nxt = -stack_top;
                        end
                        OP_CLEAR:   write_nxt  = 1'b1;
                        OP_CLR_ALL: sreset_nxt = 1'b1;
                        default: ;
                     endcase
                  end
               end
            end
         end
         S_DIV_RUN: begin
            q_nxt   = step_q;
            r_nxt   = step_r;
            cnt_nxt = div_cnt + 1'b1;
            if (div_cnt == CW'(WIDTH - 1)) begin
               state_nxt = S_EXEC;
               done_nxt  = 1'b1;
               pop_nxt   = 1'b1;
               write_nxt = 1'b1;
               value_nxt = quot_signed;
`ifdef RPN_MOD_EN
               if (div_is_mod) value_nxt = rem_signed;
`endif
            end
         end
         S_EXEC:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stack_push  <= 1'b0;
         stack_pop   <= 1'b0;
         stack_write <= 1'b0;
         stack_reset <= 1'b0;
         stack_value <= '0;
         op_done     <= 1'b0;
         err_code    <= 2'd0;
         div_q       <= '0;
         div_d       <= '0;
         div_r       <= '0;
         div_cnt     <= '0;
         div_neg_q   <= 1'b0;
`ifdef RPN_MOD_EN
         div_is_mod  <= 1'b0;
         div_neg_r   <= 1'b0;
`endif
      end else begin
         stack_push  <= push_nxt;
         stack_pop   <= pop_nxt;
         stack_write <= write_nxt;
         stack_reset <= sreset_nxt;
         stack_value <= value_nxt;
         op_done     <= done_nxt;
         err_code    <= err_nxt;
         div_q       <= q_nxt;
         div_d       <= d_nxt;
         div_r       <= r_nxt;
         div_cnt     <= cnt_nxt;
         div_neg_q   <= neg_q_nxt;
`ifdef RPN_MOD_EN
         div_is_mod  <= is_mod_nxt;
         div_neg_r   <= neg_r_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_rpn_controller.sv
// Bench for rpn_controller: vector table, stack-driven sequences, random commands against an arithmetic reference.
// Honours RPN_MOD_EN the same way as the design.
module tb_rpn_controller;

`ifdef RPN_MOD_EN
   localparam bit MOD_EN = 1'b1;
`else
   localparam bit MOD_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_op = '0;
   logic [3:0]  cmd_digit = '0;
   logic [31:0] stack_top = '0;
   logic [31:0] stack_next = '0;
   logic [5:0]  stack_count = 6'd1;
   logic        stack_error = 1'b0;
   logic        stack_push, stack_pop, stack_write, stack_reset, op_done;
   logic [31:0] stack_value;
   logic [1:0]  err_code;
   logic [1:0]  debug_state;

   rpn_controller #(.WIDTH(32), .RADIX(10)) dut (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_digit(cmd_digit), .stack_top(stack_top), .stack_next(stack_next),
      .stack_count(stack_count), .stack_error(stack_error), .stack_push(stack_push),
      .stack_pop(stack_pop), .stack_write(stack_write), .stack_value(stack_value),
      .stack_reset(stack_reset), .op_done(op_done), .err_code(err_code), .debug_state(debug_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_q[$];
   logic        sb_on = 1'b0;
   logic        watch = 1'b0;
   int          wr_seen = 0;
   logic [31:0] stk[$];

   typedef struct packed {
      logic push, pop, wr, rst;
      logic [31:0] val;
      logic [1:0]  err;
      logic        divrun;
   } exp_t;

   typedef struct packed {
      logic [3:0]  op, dg;
      logic [31:0] top, nxt;
      logic [5:0]  cnt;
      logic        serr;
      exp_t        e;
   } vec_t;

   typedef struct packed {
      logic done, push, pop, wr, rst;
      logic [31:0] val;
      logic [1:0]  err;
      int          lat;
      int          early;
      logic        after_ready, after_strobe;
      logic [1:0]  after_err;
   } obs_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (watch && stack_write) wr_seen++;
      if (sb_on && stack_write) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_unexpected_write: got %0h expected none", stack_value);
         end else begin
            check("sb_write", stack_value, exp_q.pop_front());
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic exp_t ref_model(input logic [3:0] op, input logic [3:0] dg,
                                      input logic [31:0] top, input logic [31:0] nxt,
                                      input logic [5:0] cnt, input logic serr);
      exp_t e;
      longint a, b, r;
      int depth;
      bit bin, divop;
      e = '0;
      depth = (cnt == 6'd0) ? 64 : int'(cnt);
      a = longint'($signed(nxt));
      b = longint'($signed(top));
      divop = (op == 4'd7) || (MOD_EN && op == 4'd11);
      bin = divop || (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
      if (bin && depth == 1) e.err = 2'd1;
      else if (op == 4'd2 && (depth == 64 || serr)) e.err = 2'd2;
      else if (divop && b == 0) e.err = 2'd3;
      else begin
         r = 0;
         case (op)
            4'd1: if (dg <= 4'd9) begin
               e.wr = 1'b1; e.val = 32'(longint'(top) * 10 + longint'(dg));
            end
            4'd2: e.push = 1'b1;
            4'd3: if (depth == 1) e.wr = 1'b1; else e.pop = 1'b1;
            4'd4, 4'd5, 4'd6, 4'd7, 4'd11: begin
               if (op == 4'd4) r = a + b;
               else if (op == 4'd5) r = a - b;
               else if (op == 4'd6) r = a * b;
               else if (op == 4'd7) r = a / b;
               else r = a % b;
               if (bin) begin
                  e.pop = 1'b1; e.wr = 1'b1; e.val = 32'(r); e.divrun = divop;
               end
            end
            4'd8: begin e.wr = 1'b1; e.val = 32'(-b); end
            4'd9: e.wr = 1'b1;
            4'd10: e.rst = 1'b1;
            default: ;
         endcase
      end
      return e;
   endfunction

   // ---------------- driver ----------------
   // Called #1 after a rising edge; returns #1 after a rising edge.
   task automatic run_cmd(input logic [3:0] op, input logic [3:0] dg, input logic [31:0] top,
                          input logic [31:0] nxt, input logic [5:0] cnt, input logic serr,
                          output obs_t o);
      int w;
      o = '0;
      cmd_op = op; cmd_digit = dg; stack_top = top; stack_next = nxt;
      stack_count = cnt; stack_error = serr; cmd_valid = 1'b1;
      w = 0;
      while (!cmd_ready && w < 50) begin
         @(posedge clock); #1; w++;
      end
      check("ready_wait", cmd_ready, 1);
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      stack_top = $urandom; stack_next = $urandom;
      o.lat = 1;
      while (!op_done && o.lat < 40) begin
         if (cmd_ready) o.early++;
         @(posedge clock); #1;
         o.lat++;
      end
      o.done = op_done; o.push = stack_push; o.pop = stack_pop; o.wr = stack_write;
      o.rst = stack_reset; o.val = stack_value; o.err = err_code;
      @(posedge clock); #1;
      o.after_ready  = cmd_ready;
      o.after_strobe = stack_push | stack_pop | stack_write | stack_reset | op_done;
      o.after_err    = err_code;
   endtask

   task automatic check_cmd(input string tag, input obs_t o, input exp_t e);
      check({tag, ".done"}, o.done, 1);
      check({tag, ".push"}, o.push, e.push);
      check({tag, ".pop"}, o.pop, e.pop);
      check({tag, ".write"}, o.wr, e.wr);
      check({tag, ".sreset"}, o.rst, e.rst);
      check({tag, ".err"}, o.err, e.err);
      if (e.wr) check({tag, ".value"}, o.val, e.val);
      check({tag, ".latency"}, o.lat, e.divrun ? 33 : 1);
      check({tag, ".ready_while_busy"}, o.early, 0);
      check({tag, ".ready_after"}, o.after_ready, 1);
      check({tag, ".strobe_after"}, o.after_strobe, 0);
      check({tag, ".err_hold"}, o.after_err, e.err);
   endtask

   // Stack-backed command: inputs come from the bench stack, which then reacts to the observed strobes.
   task automatic seq_cmd(input string tag, input logic [3:0] op, input logic [3:0] dg);
      logic [31:0] t, n;
      logic [5:0]  c;
      exp_t e;
      obs_t o;
      t = (stk.size() > 0) ? stk[$] : 32'd0;
      n = (stk.size() > 1) ? stk[$-1] : 32'd0;
      c = 6'(stk.size());
      e = ref_model(op, dg, t, n, c, 1'b0);
      run_cmd(op, dg, t, n, c, 1'b0, o);
      check_cmd(tag, o, e);
      if (o.rst) begin
         stk.delete(); stk.push_back(32'd0);
      end else if (o.push) begin
         if (stk.size() < 64) stk.push_back(32'd0);
      end else if (o.pop && o.wr) begin
         void'(stk.pop_back());
         if (stk.size() > 0) stk[$] = o.val;
      end else if (o.wr) begin
         if (stk.size() > 0) stk[$] = o.val;
      end else if (o.pop) begin
         if (stk.size() > 0) void'(stk.pop_back());
      end
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [3:0] dg, input logic [31:0] top,
                               input logic [31:0] nxt, input logic [5:0] cnt, input logic serr,
                               input logic push, input logic pop, input logic wr, input logic rst,
                               input logic [31:0] val, input logic [1:0] err, input logic divrun);
      vec_t v;
      v.op = op; v.dg = dg; v.top = top; v.nxt = nxt; v.cnt = cnt; v.serr = serr;
      v.e.push = push; v.e.pop = pop; v.e.wr = wr; v.e.rst = rst;
      v.e.val = val; v.e.err = err; v.e.divrun = divrun;
      return v;
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      case ($urandom_range(0, 4))
         0: w = 32'd0;
         1: w = 32'($urandom_range(0, 20)) - 32'd10;
         2: w = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
         default: w = $urandom;
      endcase
      return w;
   endfunction

   // ---------------- test ----------------
   initial begin
      vec_t vt[$];
      obs_t o;
      exp_t e;
      logic [3:0] rop, rdg;
      logic [31:0] rt, rn;
      logic [5:0] rc;
      logic rs;

      vt.push_back(mk(4'd1, 4'd3, 32'd12, 32'd0, 6'd1, 1'b0, 0, 0, 1, 0, 32'd123, 2'd0, 0));
      vt.push_back(mk(4'd1, 4'd10, 32'd5, 32'd0, 6'd1, 1'b0, 0, 0, 0, 0, 32'd0, 2'd0, 0));
      vt.push_back(mk(4'd1, 4'd7, 32'h2000_0000, 32'd0, 6'd1, 1'b0, 0, 0, 1, 0, 32'h4000_0007, 2'd0, 0));
      vt.push_back(mk(4'd2, 4'd0, 32'd9, 32'd1, 6'd5, 1'b0, 1, 0, 0, 0, 32'd0, 2'd0, 0));
      vt.push_back(mk(4'd2, 4'd0, 32'd9, 32'd1, 6'd0, 1'b0, 0, 0, 0, 0, 32'd0, 2'd2, 0));
      vt.push_back(mk(4'd2, 4'd0, 32'd9, 32'd1, 6'd3, 1'b1, 0, 0, 0, 0, 32'd0, 2'd2, 0));
      vt.push_back(mk(4'd3, 4'd0, 32'd9, 32'd0, 6'd1, 1'b0, 0, 0, 1, 0, 32'd0, 2'd0, 0));
      vt.push_back(mk(4'd3, 4'd0, 32'd9, 32'd4, 6'd4, 1'b0, 0, 1, 0, 0, 32'd0, 2'd0, 0));
      vt.push_back(mk(4'd4, 4'd0, 32'd5, 32'd7, 6'd2, 1'b0, 0, 1, 1, 0, 32'd12, 2'd0, 0));
      vt.push_back(mk(4'd4, 4'd0, 32'd1, 32'h7FFF_FFFF, 6'd2, 1'b0, 0, 1, 1, 0, 32'h8000_0000, 2'd0, 0));
      vt.push_back(mk(4'd5, 4'd0, 32'd5, 32'd2, 6'd2, 1'b0, 0, 1, 1, 0, 32'hFFFF_FFFD, 2'd0, 0));
      vt.push_back(mk(4'd6, 4'd0, 32'hFFFF_FFFD, 32'h4000_0001, 6'd2, 1'b0, 0, 1, 1, 0, 32'h3FFF_FFFD, 2'd0, 0));
      vt.push_back(mk(4'd4, 4'd0, 32'd5, 32'd7, 6'd1, 1'b0, 0, 0, 0, 0, 32'd0, 2'd1, 0));
      vt.push_back(mk(4'd7, 4'd0, 32'd2, 32'hFFFF_FFF9, 6'd2, 1'b0, 0, 1, 1, 0, 32'hFFFF_FFFD, 2'd0, 1));
      vt.push_back(mk(4'd7, 4'd0, 32'd0, 32'd9, 6'd2, 1'b0, 0, 0, 0, 0, 32'd0, 2'd3, 0));
      vt.push_back(mk(4'd7, 4'd0, 32'hFFFF_FFFF, 32'h8000_0000, 6'd2, 1'b0, 0, 1, 1, 0, 32'h8000_0000, 2'd0, 1));
      vt.push_back(mk(4'd7, 4'd0, 32'hFFFF_FFFE, 32'd7, 6'd3, 1'b0, 0, 1, 1, 0, 32'hFFFF_FFFD, 2'd0, 1));
      vt.push_back(mk(4'd8, 4'd0, 32'd5, 32'd0, 6'd1, 1'b0, 0, 0, 1, 0, 32'hFFFF_FFFB, 2'd0, 0));
      vt.push_back(mk(4'd9, 4'd0, 32'd99, 32'd0, 6'd1, 1'b0, 0, 0, 1, 0, 32'd0, 2'd0, 0));
      vt.push_back(mk(4'd10, 4'd0, 32'd99, 32'd3, 6'd7, 1'b0, 0, 0, 0, 1, 32'd0, 2'd0, 0));
      vt.push_back(mk(4'd0, 4'd0, 32'd99, 32'd3, 6'd7, 1'b0, 0, 0, 0, 0, 32'd0, 2'd0, 0));
      vt.push_back(mk(4'd12, 4'd0, 32'd99, 32'd3, 6'd7, 1'b0, 0, 0, 0, 0, 32'd0, 2'd0, 0));
      vt.push_back(mk(4'd15, 4'd0, 32'd99, 32'd3, 6'd7, 1'b0, 0, 0, 0, 0, 32'd0, 2'd0, 0));
`ifdef RPN_MOD_EN
      vt.push_back(mk(4'd11, 4'd0, 32'd2, 32'hFFFF_FFF9, 6'd2, 1'b0, 0, 1, 1, 0, 32'hFFFF_FFFF, 2'd0, 1));
      vt.push_back(mk(4'd11, 4'd0, 32'd0, 32'd9, 6'd2, 1'b0, 0, 0, 0, 0, 32'd0, 2'd3, 0));
`else
      vt.push_back(mk(4'd11, 4'd0, 32'd2, 32'hFFFF_FFF9, 6'd2, 1'b0, 0, 0, 0, 0, 32'd0, 2'd0, 0));
`endif

      // reset state
      repeat (3) @(posedge clock);
      #1;
      check("rst_ready", cmd_ready, 0);
      check("rst_push", stack_push, 0);
      check("rst_pop", stack_pop, 0);
      check("rst_write", stack_write, 0);
      check("rst_value", stack_value, 0);
      check("rst_sreset", stack_reset, 0);
      check("rst_done", op_done, 0);
      check("rst_err", err_code, 0);
      reset = 1'b1;
      #1;
      check("ready_after_release", cmd_ready, 1);
      @(posedge clock); #1;

      // vector table
      for (int i = 0; i < vt.size(); i++) begin
         run_cmd(vt[i].op, vt[i].dg, vt[i].top, vt[i].nxt, vt[i].cnt, vt[i].serr, o);
         check_cmd($sformatf("vec%0d", i), o, vt[i].e);
      end

      // digit entry on stack [0]
      stk.delete(); stk.push_back(32'd0);
      exp_q.push_back(32'd1); exp_q.push_back(32'd12); exp_q.push_back(32'd123);
      sb_on = 1'b1;
      seq_cmd("dig1", 4'd1, 4'd1);
      seq_cmd("dig2", 4'd1, 4'd2);
      seq_cmd("dig3", 4'd1, 4'd3);
      sb_on = 1'b0;
      check("sb_drained", exp_q.size(), 0);
      check("dig_top", stk[$], 32'd123);

      // [7] ENTER, DIGIT 5, SUB -> [2]
      stk.delete(); stk.push_back(32'd7);
      seq_cmd("sub_enter", 4'd2, 4'd0);
      seq_cmd("sub_digit", 4'd1, 4'd5);
      seq_cmd("sub_sub", 4'd5, 4'd0);
      check("sub_depth", stk.size(), 1);
      check("sub_top", stk[$], 32'd2);

      // [-7, 2] DIV, then NOP clears the divide-by-zero code left by [9, 0]
      stk.delete(); stk.push_back(32'hFFFF_FFF9); stk.push_back(32'd2);
      seq_cmd("seq_div", 4'd7, 4'd0);
      check("seq_div_top", stk[$], 32'hFFFF_FFFD);
      stk.delete(); stk.push_back(32'd9); stk.push_back(32'd0);
      seq_cmd("seq_div0", 4'd7, 4'd0);
      seq_cmd("seq_nop", 4'd0, 4'd0);

      // fill to 64 then overflow
      stk.delete(); stk.push_back(32'd7);
      while (stk.size() < 64 && n_cmp < 20000) seq_cmd("fill", 4'd2, 4'd0);
      check("fill_depth", stk.size(), 64);
      seq_cmd("enter_full", 4'd2, 4'd0);
      check("full_depth", stk.size(), 64);

      // random commands against the reference
      for (int i = 0; i < 250; i++) begin
         rop = 4'($urandom_range(0, 15));
         rdg = 4'($urandom_range(0, 15));
         rt  = rand_word();
         rn  = rand_word();
         rc  = ($urandom_range(0, 3) == 0) ? 6'd1 : 6'($urandom_range(0, 63));
         rs  = ($urandom_range(0, 7) == 0);
         e   = ref_model(rop, rdg, rt, rn, rc, rs);
         run_cmd(rop, rdg, rt, rn, rc, rs, o);
         check_cmd($sformatf("rnd%0d_op%0d", i, rop), o, e);
      end

      // reset in the middle of a divide
      cmd_op = 4'd7; cmd_digit = 4'd0; stack_top = 32'd2; stack_next = 32'hFFFF_FFF9;
      stack_count = 6'd2; stack_error = 1'b0;
      check("mid_ready_before", cmd_ready, 1);
      cmd_valid = 1'b1;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      watch = 1'b1;
      repeat (9) begin
         @(posedge clock); #1;
      end
      check("mid_busy", cmd_ready, 0);
      reset = 1'b0;
      #1;
      check("mid_push", stack_push, 0);
      check("mid_pop", stack_pop, 0);
      check("mid_write", stack_write, 0);
      check("mid_value", stack_value, 0);
      check("mid_sreset", stack_reset, 0);
      check("mid_done", op_done, 0);
      check("mid_err", err_code, 0);
      check("mid_ready_in_reset", cmd_ready, 0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check("mid_ready_release", cmd_ready, 1);
      repeat (40) @(posedge clock);
      #1;
      check("mid_no_write", wr_seen, 0);
      check("mid_ready_idle", cmd_ready, 1);
      watch = 1'b0;
      run_cmd(4'd10, 4'd0, 32'd5, 32'd6, 6'd3, 1'b0, o);
      e = ref_model(4'd10, 4'd0, 32'd5, 32'd6, 6'd3, 1'b0);
      check_cmd("clr_all", o, e);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rpn_controller.md
Name: rpn_controller

Overview:
- Command sequencer for the 64-entry, 32-bit calculator operand stack.
- Accepts one keypad/operator command at a time over a valid/ready handshake.
- Reads the stack's top, next and count, computes the result, and drives the stack's push/pop/write/value/reset strobes.
- Sits between the keypad decoder and the stack; the display reads the stack's top output directly.

Parameters:
- WIDTH, 32, operand width; must match the stack word width.
- RADIX, 10, digit-entry base: top <= top*RADIX + digit.

Ports:
- clock  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller accepts a command this cycle.
- cmd_op  input  4  opcode.
- cmd_digit  input  4  digit operand for DIGIT.
- stack_top  input  WIDTH  stack top element.
- stack_next  input  WIDTH  stack second element.
- stack_count  input  6  stack element count; 0 means 64.
- stack_error  input  1  stack overflow flag.
- stack_push  output  1  push strobe.
- stack_pop  output  1  pop strobe.
- stack_write  output  1  write strobe.
- stack_value  output  WIDTH  value written.
- stack_reset  output  1  synchronous clear strobe to the stack.
- op_done  output  1  one-cycle pulse when a command completes.
- err_code  output  2  0 none, 1 underflow, 2 full, 3 divide-by-zero.

Behaviour:
- Opcodes:
  - 0 NOP
  - 1 DIGIT
  - 2 ENTER
  - 3 DROP
  - 4 ADD
  - 5 SUB (next-top)
  - 6 MUL
  - 7 DIV (next/top)
  - 8 NEG
  - 9 CLEAR (top=0)
  - 10 CLR_ALL
  - 11 MOD (macro only)
  - 12-15: NOP
- States: IDLE, EXEC, DIV_RUN.
- cmd_ready = (state==IDLE) && reset deasserted.
- Accept happens on the edge where cmd_valid && cmd_ready. At that edge the controller latches the opcode, digit, stack_top, stack_next and stack_count.
- Accept in IDLE: DIV/MOD with legal operands go to DIV_RUN; every other opcode goes to EXEC.
- DIV_RUN: 32-cycle signed restoring divider on the magnitudes. Quotient truncates toward zero; remainder takes the sign of the dividend. After the 32nd cycle the controller goes to EXEC.
- EXEC lasts exactly one cycle. Stack strobes and op_done are registered and asserted only in EXEC, then the controller returns to IDLE.
- Latency: non-divide commands take 2 cycles from accept to next cmd_ready; DIV/MOD take 34.
- Strobe patterns in EXEC:
  - DIGIT: write=1, value = latched_top*RADIX + digit, mod 2^WIDTH. A digit greater than RADIX-1 gives no strobes, op_done=1, err 0.
  - ENTER: push=1 (the stack zero-fills the new top).
  - DROP: count==1 gives write=1, value=0. Otherwise pop=1.
  - ADD/SUB/MUL/DIV/MOD: pop=1, write=1, value=result. The stack writes at pointer-1.
  - MUL keeps the low WIDTH bits of the signed product.
  - Two's-complement wrap on all arithmetic; e.g. 0x80000000 / -1 gives 0x80000000.
  - NEG: write=1, value = -top.
  - CLEAR: write=1, value=0.
  - CLR_ALL: stack_reset=1.
  - NOP: op_done only.
- Error checks are made at accept. A command that errors still passes through EXEC with op_done=1 and no stack strobes.
  - Binary op with latched count==1: err 1.
  - ENTER with count==0 or stack_error=1: err 2.
  - DIV/MOD with top==0: err 3, and the controller skips DIV_RUN.
- err_code is set in EXEC and held until the next accept, which clears it to 0.
- Only one of push/pop/write-group (or stack_reset) per command. push and pop are never both asserted.
- cmd_valid while not ready is ignored; the command is neither dropped nor latched. The upstream block holds cmd_valid.
- Reset low at any time: state=IDLE, all strobes 0, stack_value 0, op_done 0, err_code 0, divider cleared. Any in-flight divide is abandoned with no stack write.
- After release, cmd_ready is 1 on the first cycle.

Optional Feature:
- RPN_MOD_EN defined: opcode 11 MOD is supported. It uses the shared divider and writes the remainder of next/top.
- RPN_MOD_EN undefined: opcode 11 is a NOP and no remainder register is kept.

Test Plan:
- Reset, then DIGIT 1, DIGIT 2, DIGIT 3 -> three writes with values 1, 12, 123; err_code 0; each op_done 2 cycles after accept.
- Stack [7], ENTER, DIGIT 5, SUB -> push, write 5, then pop+write with value 2; count returns to 1.
- Stack [-7, 2], DIV -> cmd_ready low for 34 cycles, then pop+write with value -3 (0xFFFFFFFD). With RPN_MOD_EN, MOD on the same stack -> value -1.
- Stack [9, 0], DIV -> no DIV_RUN, no strobes, err_code 3, op_done 2 cycles after accept. Next NOP -> err_code 0.
- Count==1, ADD -> err_code 1, no strobes. Fill to 64 with ENTERs (count==0), ENTER -> err_code 2, no push.
- Reset asserted low mid-DIV_RUN (cycle 10) -> all outputs 0 immediately, no stack_write ever issued, cmd_ready 1 after release. CLR_ALL -> single-cycle stack_reset pulse.
